// File: rtl/unstrip_pkg.sv
// -----------------------------------------------------------------------------
// unstrip_pkg
// Shared types and constants for the 4-lane byte-unstriping controller.
//   state_t   : controller FSM encoding (IDLE / ALIGN / RUN / ERR)
//   sym_t     : one lane symbol, K-flag plus data byte (9 bits)
//   is_com()  : true when a symbol is the K-coded alignment character
// -----------------------------------------------------------------------------
package unstrip_pkg;

   localparam int         NUM_LANES   = 4;
   localparam int         LANE_IDX_W  = 2;
   localparam logic [7:0] COM_SYM_DEF = 8'hBC;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ALIGN = 2'd1,
      ST_RUN   = 2'd2,
      ST_ERR   = 2'd3
   } state_t;

   typedef struct packed {
      logic       k;
      logic [7:0] data;
   } sym_t;

   // COM is only an alignment marker when it arrives as a K symbol.
   function automatic logic is_com(input sym_t s, input logic [7:0] com);
      return s.k && (s.data == com);
   endfunction

endpackage

// File: rtl/lane_fifo.sv
// -----------------------------------------------------------------------------
// lane_fifo
// Per-lane synchronous FIFO holding K-flag + data symbols.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   flush        : synchronous empty (wins over wr/rd)
//   wr, din      : push request and symbol (ignored when full unless popping)
//   rd, dout     : pop request (ignored when empty); dout is the current head
//   full, empty  : occupancy flags
//   count        : number of stored symbols, 0..DEPTH
// -----------------------------------------------------------------------------
module lane_fifo
   import unstrip_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   wr,
   input  logic                   rd,
   input  sym_t                   din,
   output sym_t                   dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   sym_t             mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign full  = (count == (PTR_W + 1)'(DEPTH));
   assign empty = (count == '0);
   assign dout  = mem[rd_ptr];

   // A full FIFO may still accept a write when the head leaves the same cycle.
   assign do_rd = rd && !empty;
   assign do_wr = wr && (!full || do_rd);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; count/pointers define validity,
   // and leaving the array reset-free lets it map onto plain RAM/flops.
   always_ff @(posedge clk) begin
      if (do_wr && !flush) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/unstrip_align_ctrl.sv
// -----------------------------------------------------------------------------
// unstrip_align_ctrl
// Buffers four byte lanes, deskews them on the COM K-symbol and serialises
// them round-robin (lane 0,1,2,3) as one byte per clock.
// Ports:
//   CLK, RESET          : clock, asynchronous active-high reset
//   ENABLE              : 1 = align/serialise, 0 = flush back to IDLE
//   LANE0..3, DK_0..3   : per-lane symbol and K-flag
//   LANE_VALID[3:0]     : per-lane symbol valid
//   D, DK, D_VALID      : serialised byte, its K-flag, and valid
//   LANE_SEL            : lane scheduled for the next pop
//   LANE_LOCK[3:0]      : lane has seen COM
//   ALIGNED             : controller is in RUN
//   ALIGN_ERR           : sticky timeout/overflow flag, cleared by ENABLE=0
// -----------------------------------------------------------------------------
module unstrip_align_ctrl
   import unstrip_pkg::*;
#(
   parameter int         FIFO_DEPTH = 4,
   parameter int         ALIGN_TMO  = 64,
   parameter logic [7:0] COM_SYM    = COM_SYM_DEF
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  ENABLE,
   input  logic [7:0]            LANE0,
   input  logic [7:0]            LANE1,
   input  logic [7:0]            LANE2,
   input  logic [7:0]            LANE3,
   input  logic                  DK_0,
   input  logic                  DK_1,
   input  logic                  DK_2,
   input  logic                  DK_3,
   input  logic [NUM_LANES-1:0]  LANE_VALID,
   output logic [7:0]            D,
   output logic                  DK,
   output logic                  D_VALID,
   output logic [LANE_IDX_W-1:0] LANE_SEL,
   output logic [NUM_LANES-1:0]  LANE_LOCK,
   output logic                  ALIGNED,
   output logic                  ALIGN_ERR
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int TMO_W = $clog2(ALIGN_TMO) + 1;

   state_t               state;
   logic [TMO_W-1:0]     tmo_cnt;

   sym_t                 lane_sym [NUM_LANES];
   sym_t                 head     [NUM_LANES];
   logic [CNT_W-1:0]     count    [NUM_LANES];
   logic [NUM_LANES-1:0] full;
   logic [NUM_LANES-1:0] empty;
   logic [NUM_LANES-1:0] wr_req;
   logic [NUM_LANES-1:0] wr_en;
   logic [NUM_LANES-1:0] rd_en;
   logic                 accepting;
   logic                 overflow;
   logic                 flush;
   logic                 unused_count;

   assign lane_sym[0] = {DK_0, LANE0};
   assign lane_sym[1] = {DK_1, LANE1};
   assign lane_sym[2] = {DK_2, LANE2};
   assign lane_sym[3] = {DK_3, LANE3};

   assign ALIGNED   = (state == ST_RUN);
   assign flush     = !ENABLE;
   assign accepting = ENABLE && ((state == ST_ALIGN) || (state == ST_RUN));

   // Occupancy is only needed at the FIFO boundary; the scheduler works on
   // the empty/full flags.
   assign unused_count = ^{count[0], count[1], count[2], count[3]};

   // NOTE: every always_comb output gets a default before any condition so
   // no path leaves it unassigned (which would infer a latch).
   always_comb begin
      wr_req = '0;
      rd_en  = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         // Unlocked lanes drop everything except their first COM.
         wr_req[k] = accepting && LANE_VALID[k] &&
                     (LANE_LOCK[k] || is_com(lane_sym[k], COM_SYM));
      end
      // Strict round-robin: an empty scheduled lane stalls, never skipped.
      if (ENABLE && (state == ST_RUN) && !empty[LANE_SEL]) rd_en[LANE_SEL] = 1'b1;
      wr_en    = wr_req & (~full | rd_en);
      overflow = |(wr_req & full & ~rd_en);
   end

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      lane_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
         .clk   (CLK),
         .rst   (RESET),
         .flush (flush),
         .wr    (wr_en[g]),
         .rd    (rd_en[g]),
         .din   (lane_sym[g]),
         .dout  (head[g]),
         .full  (full[g]),
         .empty (empty[g]),
         .count (count[g])
      );
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state     <= ST_IDLE;
         tmo_cnt   <= '0;
         LANE_SEL  <= '0;
         LANE_LOCK <= '0;
         D         <= '0;
         DK        <= 1'b0;
         D_VALID   <= 1'b0;
         ALIGN_ERR <= 1'b0;
      end else if (!ENABLE) begin
         state     <= ST_IDLE;
         tmo_cnt   <= '0;
         LANE_SEL  <= '0;
         LANE_LOCK <= '0;
         D_VALID   <= 1'b0;
         ALIGN_ERR <= 1'b0;
      end else begin
         D_VALID <= 1'b0;
         case (state)
            ST_IDLE: begin
               tmo_cnt <= '0;
               state   <= ST_ALIGN;
            end

            ST_ALIGN: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               for (int k = 0; k < NUM_LANES; k++) begin
                  if (wr_req[k]) LANE_LOCK[k] <= 1'b1;
               end
               // Exit decision uses the registered lock vector, so the last
               // COM is already in its FIFO when RUN starts.
               if (overflow) begin
                  state     <= ST_ERR;
                  ALIGN_ERR <= 1'b1;
               end else if (&LANE_LOCK) begin
                  state    <= ST_RUN;
                  LANE_SEL <= '0;
               end else if (tmo_cnt == TMO_W'(ALIGN_TMO - 1)) begin
                  state     <= ST_ERR;
                  ALIGN_ERR <= 1'b1;
               end
            end

            ST_RUN: begin
               if (!empty[LANE_SEL]) begin
                  D        <= head[LANE_SEL].data;
                  DK       <= head[LANE_SEL].k;
                  D_VALID  <= 1'b1;
                  LANE_SEL <= LANE_SEL + 1'b1;
               end
               if (overflow) begin
                  state     <= ST_ERR;
                  ALIGN_ERR <= 1'b1;
                  D_VALID   <= 1'b0;
               end
            end

            default: begin
               // ST_ERR: frozen until ENABLE drops.
               state <= ST_ERR;
            end
         endcase
      end
   end

endmodule

// File: doc/unstrip_align_ctrl.md
Name: unstrip_align_ctrl

Overview:
- Controls and sequences the 4-lane byte-unstriping datapath.
- Buffers each lane's received symbols in its own small FIFO, deskews the lanes against the COM alignment symbol, then serialises bytes round-robin (lane 0, 1, 2, 3).
- Output is one byte per CLK, with valid and K-flag.
- Sits between the per-lane receivers and the byte-level consumer; replaces free-running lane counters with a handshaked, alignment-aware scheduler.

Parameters:
FIFO_DEPTH  4      per-lane FIFO entries, power of 2, >=2
ALIGN_TMO   64     CLK cycles allowed in ALIGN before error
COM_SYM     8'hBC  alignment symbol, valid only with DK=1

Ports:
CLK        in   1  clock, all logic on posedge
RESET      in   1  asynchronous, active-high reset
ENABLE     in   1  1=run alignment/serialisation; 0=flush to IDLE
LANE0      in   8  lane 0 symbol
LANE1      in   8  lane 1 symbol
LANE2      in   8  lane 2 symbol
LANE3      in   8  lane 3 symbol
DK_0       in   1  lane 0 K-flag
DK_1       in   1  lane 1 K-flag
DK_2       in   1  lane 2 K-flag
DK_3       in   1  lane 3 K-flag
LANE_VALID in   4  bit k: LANEk/DK_k valid this cycle
D          out  8  serialised byte
DK         out  1  K-flag of D
D_VALID    out  1  D/DK valid this cycle
LANE_SEL   out  2  lane currently scheduled for pop
LANE_LOCK  out  4  bit k: lane k has seen COM
ALIGNED    out  1  state==RUN
ALIGN_ERR  out  1  sticky error flag

Behaviour:
- Reset (async, immediate) sets all outputs to 0, empties all FIFOs, clears locks and the timeout counter, and puts the FSM in IDLE.
- FSM states are IDLE, ALIGN, RUN, ERR. ENABLE=0 in any state forces IDLE at the next edge, flushing FIFOs and clearing LANE_LOCK and ALIGN_ERR.
- IDLE: goes to ALIGN when ENABLE=1. No writes, D_VALID=0.
- ALIGN, per lane k:
  - While LANE_LOCK[k]=0, valid symbols are discarded unless DK_k=1 and LANEk==COM_SYM.
  - That COM sets LANE_LOCK[k] and is written to the FIFO.
  - Subsequent valid symbols are written.
- ALIGN exit and timeout:
  - When LANE_LOCK==4'hF (registered), go to RUN next edge with LANE_SEL=0.
  - The timeout counter increments every ALIGN cycle; reaching ALIGN_TMO goes to ERR.
- RUN: each cycle, if FIFO[LANE_SEL] is non-empty:
  - Pop it.
  - Register D/DK from the head, D_VALID=1 next cycle.
  - LANE_SEL increments mod 4 (3 wraps to 0).
  - If it is empty: D_VALID=0 next cycle and LANE_SEL holds (stall, never skip a lane).
- Latency: a symbol written at edge t is poppable at t+1; D appears at t+2 minimum.
- Overflow: a write to a full FIFO with no pop in the same cycle, in ALIGN or RUN, goes to ERR. ALIGN_ERR=1 and the symbol is dropped. A simultaneous pop and write on a full FIFO is legal and the count is unchanged.
- Writes continue in RUN for all lanes, independent of LANE_SEL.
- ERR: D_VALID=0, no pops, no writes, ALIGN_ERR held at 1 until ENABLE=0.
- D and DK hold their last value when D_VALID=0.
- FIFO counts are log2(FIFO_DEPTH)+1 bits. Pointers wrap naturally.

Decomposition:
- Package unstrip_pkg holds:
  - FSM state encoding (IDLE/ALIGN/RUN/ERR)
  - COM_SYM default
  - NUM_LANES=4
  - lane-index width 2
- One sub-module, lane_fifo: synchronous 9-bit-wide FIFO (DK + data) with wr, rd, flush, full, empty and count outputs. It is instantiated 4 times.
- The controller holds the FSM, lock logic, timeout and round-robin pointer.

Test Plan:
1. Assert RESET mid-RUN with FIFOs non-empty -> D=0, DK=0, D_VALID=0, LANE_SEL=0, LANE_LOCK=0, ALIGNED=0 immediately. After release and ENABLE=1, FSM is in ALIGN.
2. Zero skew: all lanes send COM on the same cycle, then lanes 0-3 send 0x10,0x11,0x12,0x13 -> ALIGNED=1, then D=BC(DK1)x4, then 10,11,12,13 (DK0) on consecutive cycles.
3. Skew: lane 2 sends 0x55,0x66 before its COM, 2 beats after the other lanes -> garbage dropped, LANE_LOCK goes 1011 then 1111, output identical to scenario 2.
4. Stall: in RUN, lane 3 VALID withheld one beat -> at LANE_SEL=3, D_VALID=0 and LANE_SEL=3 held until the lane 3 write, then the byte is output in order.
5. Overflow: lanes 0-2 locked, lane 0 writes 5 symbols with DEPTH=4 while lane 3 never locks -> ALIGN_ERR=1, ERR state, D_VALID=0. ENABLE=0 -> IDLE, ALIGN_ERR=0, FIFOs empty.
6. Timeout: lane 3 never sends COM and no overflow occurs -> ALIGN_ERR=1 exactly 64 cycles after entering ALIGN.
